dmem_mc: RTL and testbench

DMEM_MC -- requirements
Module: dmem_mc

---
 rtl/dmem_mc_pkg.sv | 34 +++
 rtl/dmem_mc_if.sv | 26 ++
 rtl/dmem_mc_align.sv | 49 ++++
 rtl/dmem_mc.sv | 121 ++++++++++++
 tb/tb_dmem_mc.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_mc_pkg.sv
// Shared types and constants for the dmem_mc multi-cycle data memory.
package dmem_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_t;

  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 15;

  // A request flagged as both byte and half-word is a byte access.
  function automatic size_t decode_size(input logic is_byte, input logic is_half);
    if (is_byte)      return SZ_BYTE;
    else if (is_half) return SZ_HALF;
    else              return SZ_WORD;
  endfunction

  function automatic logic [2:0] size_bytes(input size_t sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_mc_if.sv
// Request/response bus of dmem_mc; master drives requests, slave answers.
interface dmem_mc_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic        req_byte;
  logic        req_half_word;
  logic        req_sign_extend;
  logic [31:0] req_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_error;

  modport master (
    output req_valid, req_addr, req_write, req_byte, req_half_word,
           req_sign_extend, req_data,
    input  req_ready, resp_valid, resp_data, resp_error
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_byte, req_half_word,
           req_sign_extend, req_data,
    output req_ready, resp_valid, resp_data, resp_error
  );
endinterface

// File: rtl/dmem_mc_align.sv
// Big-endian byte-lane steering: load extract/extend and store lane enables.
module dmem_mc_align
  import dmem_mc_pkg::*;
(
  input  size_t       i_size,
  input  logic        i_sext,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rd_word,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_ld_data,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_word
);

  logic [4:0]  w_shift;
  logic [31:0] w_rot;

  // Byte at offset 0 sits in bits [31:24]; misaligned low bits are dropped.
  always_comb begin
    w_shift   = '0;
    o_ld_data = '0;
    o_st_be   = '0;
    o_st_word = '0;
    case (i_size)
      SZ_BYTE: w_shift = {~i_addr_lo, 3'b000};
      SZ_HALF: w_shift = {~i_addr_lo[1], 4'b0000};
      default: w_shift = '0;
    endcase
    w_rot = i_rd_word >> w_shift;
    case (i_size)
      SZ_BYTE: begin
        o_ld_data = {{24{i_sext & w_rot[7]}}, w_rot[7:0]};
        o_st_be   = 4'b1000 >> i_addr_lo;
        o_st_word = {4{i_st_data[7:0]}};
      end
      SZ_HALF: begin
        o_ld_data = {{16{i_sext & w_rot[15]}}, w_rot[15:0]};
        o_st_be   = i_addr_lo[1] ? 4'b0011 : 4'b1100;
        o_st_word = {2{i_st_data[15:0]}};
      end
      default: begin
        o_ld_data = i_rd_word;
        o_st_be   = 4'b1111;
        o_st_word = i_st_data;
      end
    endcase
  end

endmodule

// File: rtl/dmem_mc.sv
// Multi-cycle big-endian data memory with fixed response latency.
// Optional: define DMEM_MC_MISALIGN_TRAP_EN to report misaligned accesses as errors.
module dmem_mc
  import dmem_mc_pkg::*;
#(
  parameter int unsigned SIZE    = 16384,
  parameter int unsigned LATENCY = 2
) (
  input  logic      clock,
  input  logic      reset,
  dmem_mc_if.slave  bus
);

  localparam int unsigned AW       = $clog2(SIZE);
  localparam logic [32:0] SIZE_EXT = 33'(SIZE);
  localparam logic [3:0]  CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("dmem_mc: LATENCY out of range");
  end

  logic [7:0] mem [0:SIZE-1];

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_addr, r_data;
  logic        r_write, r_sext;
  size_t       r_size;

  logic          w_accept, w_resp, w_oor, w_mis, w_err, w_we;
  logic [AW-3:0] w_word;
  logic [31:0]   w_rd_word, w_ld_data, w_st_word;
  logic [3:0]    w_st_be;

  assign bus.req_ready = (r_state == ST_IDLE) && !reset;
  assign w_accept      = bus.req_valid && bus.req_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_write <= 1'b0;
      r_sext  <= 1'b0;
      r_size  <= SZ_WORD;
    end else if (w_accept) begin
      r_addr  <= bus.req_addr;
      r_data  <= bus.req_data;
      r_write <= bus.req_write;
      r_sext  <= bus.req_sign_extend;
      r_size  <= decode_size(bus.req_byte, bus.req_half_word);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        w_state_nxt = (LATENCY == 1) ? ST_RESP : ST_BUSY;
        w_cnt_nxt   = CNT_LOAD;
      end
      ST_BUSY: begin
        if (r_cnt == '0) w_state_nxt = ST_RESP;
        else             w_cnt_nxt   = r_cnt - 4'd1;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Range check uses the raw address so a forced-aligned word cannot sneak in.
  assign w_oor = ({1'b0, r_addr} + {30'b0, size_bytes(r_size)}) > SIZE_EXT;
`ifdef DMEM_MC_MISALIGN_TRAP_EN
  assign w_mis = ((r_size == SZ_HALF) && r_addr[0]) ||
                 ((r_size == SZ_WORD) && (r_addr[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif
  assign w_err  = w_oor || w_mis;
  assign w_resp = (r_state == ST_RESP) && !reset;
  assign w_we   = w_resp && r_write && !w_err;

  assign w_word    = r_addr[AW-1:2];
  assign w_rd_word = {mem[{w_word, 2'd0}], mem[{w_word, 2'd1}],
                      mem[{w_word, 2'd2}], mem[{w_word, 2'd3}]};

  dmem_mc_align u_align (
    .i_size    (r_size),
    .i_sext    (r_sext),
    .i_addr_lo (r_addr[1:0]),
    .i_rd_word (w_rd_word),
    .i_st_data (r_data),
    .o_ld_data (w_ld_data),
    .o_st_be   (w_st_be),
    .o_st_word (w_st_word)
  );

  always_ff @(posedge clock) begin
    if (w_we) begin
      if (w_st_be[3]) mem[{w_word, 2'd0}] <= w_st_word[31:24];
      if (w_st_be[2]) mem[{w_word, 2'd1}] <= w_st_word[23:16];
      if (w_st_be[1]) mem[{w_word, 2'd2}] <= w_st_word[15:8];
      if (w_st_be[0]) mem[{w_word, 2'd3}] <= w_st_word[7:0];
    end
  end

  assign bus.resp_valid = w_resp;
  assign bus.resp_data  = (w_resp && !r_write && !w_err) ? w_ld_data : '0;
  assign bus.resp_error = w_resp && w_err;

endmodule

// File: tb/tb_dmem_mc.sv
// Directed bench for dmem_mc: one instance at LATENCY=2, one at LATENCY=1.
module tb_dmem_mc;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  dmem_mc_if b0();
  dmem_mc_if b1();

  dmem_mc #(.SIZE(16384), .LATENCY(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (b0)
  );

  dmem_mc #(.SIZE(16384), .LATENCY(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (b1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus;
    b0.req_valid = 1'b0; b0.req_addr = '0; b0.req_write = 1'b0; b0.req_byte = 1'b0;
    b0.req_half_word = 1'b0; b0.req_sign_extend = 1'b0; b0.req_data = '0;
    b1.req_valid = 1'b0; b1.req_addr = '0; b1.req_write = 1'b0; b1.req_byte = 1'b0;
    b1.req_half_word = 1'b0; b1.req_sign_extend = 1'b0; b1.req_data = '0;
  endtask

  // One request on the LATENCY=2 instance; expects the response 2 cycles after accept.
  task automatic req0(input logic wr, input logic by, input logic hw, input logic sx,
                      input logic [31:0] addr, input logic [31:0] data,
                      output logic [31:0] rd, output logic er);
    int lat;
    b0.req_write = wr; b0.req_byte = by; b0.req_half_word = hw;
    b0.req_sign_extend = sx; b0.req_addr = addr; b0.req_data = data;
    b0.req_valid = 1'b1;
    chk("ready_before_accept", 32'(b0.req_ready), 32'd1);
    chk("idle_resp_data_zero", b0.resp_data, 32'd0);
    lat = 0; rd = '0; er = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock); #1;
      b0.req_valid = 1'b0;
      if (b0.resp_valid) begin
        lat = n; rd = b0.resp_data; er = b0.resp_error;
        break;
      end
    end
    chk("latency", 32'(lat), 32'd2);
    @(posedge clock); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  logic        saw;
  logic [5:0]  acc, rsp;

  initial begin
    idle_bus();
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rst_ready", 32'(b0.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(b0.resp_valid), 32'd0);
    chk("rst_resp_data", b0.resp_data, 32'd0);
    chk("rst_resp_error", 32'(b0.resp_error), 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 32'(b0.req_ready), 32'd1);
    chk("ready_after_reset_l1", 32'(b1.req_ready), 32'd1);

    // Word store then load
    req0(1'b1, 1'b0, 1'b0, 1'b0, 32'h2000, 32'hDEADBEEF, rd, er);
    chk("st_word_data", rd, 32'd0);
    chk("st_word_err", 32'(er), 32'd0);
    chk("mem_2000", 32'(dut.mem[14'h2000]), 32'h0000_00DE);
    chk("mem_2003", 32'(dut.mem[14'h2003]), 32'h0000_00EF);
    req0(1'b0, 1'b0, 1'b0, 1'b0, 32'h2000, 32'h0, rd, er);
    chk("ld_word", rd, 32'hDEADBEEF);
    chk("ld_word_err", 32'(er), 32'd0);

    // Sub-word loads with sign/zero extension
    dut.mem[14'h2001] = 8'h80;
    req0(1'b0, 1'b1, 1'b0, 1'b1, 32'h2001, 32'h0, rd, er);
    chk("ld_byte_sext", rd, 32'hFFFF_FF80);
    req0(1'b0, 1'b1, 1'b0, 1'b0, 32'h2001, 32'h0, rd, er);
    chk("ld_byte_zext", rd, 32'h0000_0080);
    req0(1'b0, 1'b1, 1'b1, 1'b1, 32'h2001, 32'h0, rd, er);
    chk("ld_byte_half_both", rd, 32'hFFFF_FF80);

    // Half store into a preloaded word
    dut.mem[14'h2000] = 8'hAA; dut.mem[14'h2001] = 8'hBB;
    dut.mem[14'h2002] = 8'hCC; dut.mem[14'h2003] = 8'hDD;
    req0(1'b1, 1'b0, 1'b1, 1'b0, 32'h2002, 32'hFFFF1234, rd, er);
    req0(1'b0, 1'b0, 1'b0, 1'b0, 32'h2000, 32'h0, rd, er);
    chk("ld_after_half_st", rd, 32'hAABB1234);

    // Misaligned word load
    req0(1'b0, 1'b0, 1'b0, 1'b0, 32'h2001, 32'h0, rd, er);
`ifdef DMEM_MC_MISALIGN_TRAP_EN
    chk("misalign_data", rd, 32'd0);
    chk("misalign_err", 32'(er), 32'd1);
`else
    chk("misalign_data", rd, 32'hAABB1234);
    chk("misalign_err", 32'(er), 32'd0);
`endif

    // Range boundaries: last byte legal, first byte past the end rejected
    dut.mem[14'h3FFF] = 8'h7E;
    dut.mem[14'h0000] = 8'h5A;
    req0(1'b0, 1'b1, 1'b0, 1'b0, 32'h3FFF, 32'h0, rd, er);
    chk("ld_last_byte", rd, 32'h0000_007E);
    chk("ld_last_byte_err", 32'(er), 32'd0);
    req0(1'b1, 1'b1, 1'b0, 1'b0, 32'h4000, 32'hFF, rd, er);
    chk("oor_store_err", 32'(er), 32'd1);
    chk("oor_store_data", rd, 32'd0);
    chk("oor_no_wrap_write", 32'(dut.mem[14'h0000]), 32'h0000_005A);

    // Reset while BUSY abandons the store
    b0.req_write = 1'b1; b0.req_byte = 1'b0; b0.req_half_word = 1'b0;
    b0.req_addr = 32'h2000; b0.req_data = 32'h11223344; b0.req_valid = 1'b1;
    @(posedge clock); #1;
    b0.req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    saw = b0.resp_valid;
    chk("busy_rst_ready", 32'(b0.req_ready), 32'd0);
    @(posedge clock); #1;
    saw = saw | b0.resp_valid;
    reset = 1'b0;
    #1;
    chk("ready_after_busy_rst", 32'(b0.req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      saw = saw | b0.resp_valid;
    end
    chk("busy_rst_no_resp", 32'(saw), 32'd0);
    chk("busy_rst_mem", 32'(dut.mem[14'h2000]), 32'h0000_00AA);

    // LATENCY=1 back-to-back with valid held high
    dut1.mem[14'h0100] = 8'h01; dut1.mem[14'h0101] = 8'h02;
    dut1.mem[14'h0102] = 8'h03; dut1.mem[14'h0103] = 8'h04;
    b1.req_write = 1'b0; b1.req_addr = 32'h0100; b1.req_valid = 1'b1;
    acc = '0; rsp = '0;
    for (int k = 0; k < 6; k++) begin
      acc[k] = b1.req_ready && b1.req_valid;
      @(posedge clock); #1;
      rsp[k] = b1.resp_valid;
      if (rsp[k]) chk("b2b_data", b1.resp_data, 32'h01020304);
    end
    b1.req_valid = 1'b0;
    chk("b2b_accept_pattern", 32'(acc), 32'h15);
    chk("b2b_resp_pattern", 32'(rsp), 32'h15);

    b1.req_addr = 32'h3FFE; b1.req_valid = 1'b1;
    chk("l1_oor_ready", 32'(b1.req_ready), 32'd1);
    @(posedge clock); #1;
    b1.req_valid = 1'b0;
    chk("l1_oor_valid", 32'(b1.resp_valid), 32'd1);
    chk("l1_oor_err", 32'(b1.resp_error), 32'd1);
    chk("l1_oor_data", b1.resp_data, 32'd0);
    @(posedge clock); #1;
    chk("l1_resp_cleared", 32'(b1.resp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
